// File: rtl/order_ledger.sv
// order_ledger: evaluates orders against a trading limit using running
// accumulated/cancelled ledgers, and returns an accept/reject response.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   max_to_trade    - signed trading limit, captured with each order
//   ord_*           - order request channel (valid/ready)
//   cxl_*           - cancel events, always accepted
//   rsp_*           - response channel (valid/ready)
//   accumulated_orders, cancelled_orders - registered ledger counters
module order_ledger #(
  parameter int W    = 32,
  parameter int ID_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    max_to_trade,
  input  logic            ord_valid,
  output logic            ord_ready,
  input  logic [W-1:0]    ord_amount,
  input  logic [ID_W-1:0] ord_id,
  input  logic            cxl_valid,
  input  logic [W-1:0]    cxl_amount,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_accept,
  output logic [W-1:0]    rsp_future,
  output logic [W-1:0]    accumulated_orders,
  output logic [W-1:0]    cancelled_orders
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t state;
  state_t state_nx;

  logic [W-1:0]    amt_q;
  logic [W-1:0]    max_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    cxl_q;
  logic [W-1:0]    future;
  logic            reject;
  logic            ord_hs;
  logic            rsp_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ord_hs) state_nx = EVAL;
      EVAL: state_nx = RESP;
      RESP: if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ord_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: ord_ready = 1'b1;
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign ord_hs = ord_valid && ord_ready;
  assign rsp_hs = rsp_valid && rsp_ready;

  // Uses the counters as they stand at the start of the EVAL cycle;
  // a cancel arriving in the same cycle lands after this evaluation.
  assign future = acc_q + amt_q + (~cxl_q + ONE);
  assign reject = $signed(max_q) < $signed(future);

  always_ff @(posedge clk) begin
    if (reset) begin
      amt_q      <= '0;
      max_q      <= '0;
      id_q       <= '0;
      acc_q      <= '0;
      cxl_q      <= '0;
      rsp_id     <= '0;
      rsp_accept <= 1'b0;
      rsp_future <= '0;
    end else begin
      if (ord_hs) begin
        amt_q <= ord_amount;
        max_q <= max_to_trade;
        id_q  <= ord_id;
      end
      // Response fields only change here, so they hold through RESP.
      if (state == EVAL) begin
        rsp_id     <= id_q;
        rsp_accept <= !reject;
        rsp_future <= future;
        if (!reject) acc_q <= acc_q + amt_q;
      end
      if (cxl_valid) cxl_q <= cxl_q + cxl_amount;
    end
  end

  assign accumulated_orders = acc_q;
  assign cancelled_orders   = cxl_q;

endmodule
